// File: rtl/idct_pkg.sv
// Shared constants, types and arithmetic helpers for the 8-point row IDCT.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
// Contents: cosine table for CW=16/CFRAC=14, FSM state type, accumulator
// sizing helper and the output round/saturate helper.
package idct_pkg;

    localparam int N_PTS  = 8;
    localparam int TAB_CW = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC,
        FIN,
        OUT
    } state_t;

    // COS_TAB[k][n] = round(2^14 * c(k)/2 * cos((2n+1)*k*pi/16)),
    // c(0) = 1/sqrt(2), c(k>0) = 1.
    localparam logic signed [TAB_CW-1:0] COS_TAB [N_PTS][N_PTS] = '{
        '{ 16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793},
        '{ 16'sd8035,  16'sd6811,  16'sd4551,  16'sd1598, -16'sd1598, -16'sd4551, -16'sd6811, -16'sd8035},
        '{ 16'sd7568,  16'sd3135, -16'sd3135, -16'sd7568, -16'sd7568, -16'sd3135,  16'sd3135,  16'sd7568},
        '{ 16'sd6811, -16'sd1598, -16'sd8035, -16'sd4551,  16'sd4551,  16'sd8035,  16'sd1598, -16'sd6811},
        '{ 16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793,  16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793},
        '{ 16'sd4551, -16'sd8035,  16'sd1598,  16'sd6811, -16'sd6811, -16'sd1598,  16'sd8035, -16'sd4551},
        '{ 16'sd3135, -16'sd7568,  16'sd7568, -16'sd3135, -16'sd3135,  16'sd7568, -16'sd7568,  16'sd3135},
        '{ 16'sd1598, -16'sd4551,  16'sd6811, -16'sd8035,  16'sd8035, -16'sd6811,  16'sd4551, -16'sd1598}
    };

    // Eight products of DW+CW bits can grow by at most 3 bits.
    function automatic int acc_width(input int dw, input int cw);
        return dw + cw + 3;
    endfunction

    // Round half up by adding 2^(frac-1), arithmetic shift, then clip to a
    // signed ow-bit range. Callers sign-extend their accumulator to 64 bits.
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                     input int frac,
                                                     input int ow);
        logic signed [63:0] v;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        v  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/idct_cos_rom.sv
// Cosine coefficient lookup T[k][n], one read port per MAC lane.
// Latency: combinational.
// Backpressure: none; pure lookup.
// Ports: i_k  - coefficient index shared by all lanes
//        i_n  - per-lane output index, lane l at [l*3 +: 3]
//        o_t  - per-lane signed table entry, lane l at [l*CW +: CW]
module idct_cos_rom
    import idct_pkg::*;
#(
    parameter int CW    = 16,
    parameter int LANES = 1
) (
    input  logic [2:0]          i_k,
    input  logic [3*LANES-1:0]  i_n,
    output logic [CW*LANES-1:0] o_t
);

    // Table is generated for 16-bit entries; other CW values are a plain
    // signed resize of the same constants.
    for (genvar l = 0; l < LANES; l++) begin : g_port
        assign o_t[l*CW +: CW] = CW'(COS_TAB[i_k][i_n[l*3 +: 3]]);
    end

endmodule

// File: rtl/idct_row_pipe.sv
// Signed 8-point 1-D row IDCT over LANES parallel MAC lanes, rounded and saturated.
// Latency: accept edge to out_valid = 64/LANES + 2 cycles; one row in flight.
// Backpressure: in_ready low from accept until output handshake; out_samples held while out_ready low.
// Ports: clk/rst (sync, active high); in_valid/in_ready/in_coeffs (X[k] at [k*DW +: DW]);
//        out_valid/out_ready/out_samples (x[n] at [n*OW +: OW]); busy high whenever a row is in flight.
module idct_row_pipe
    import idct_pkg::*;
#(
    parameter int DW    = 16,
    parameter int OW    = 16,
    parameter int CW    = 16,
    parameter int CFRAC = 14,
    parameter int LANES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [8*DW-1:0] in_coeffs,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [8*OW-1:0] out_samples,
    output logic            busy
);

    localparam int ACCW   = acc_width(DW, CW);
    localparam int PW     = DW + CW;
    localparam int GROUPS = N_PTS / LANES;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    state_t               r_state;
    logic signed [DW-1:0] r_row [N_PTS];
    logic [2:0]           r_k;
    logic [GW-1:0]        r_g;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_busy;
    logic [8*OW-1:0]      r_out;

    logic signed [DW-1:0] w_x;
    logic [3*LANES-1:0]   w_n;
    logic [CW*LANES-1:0]  w_t;
    logic [8*OW-1:0]      w_res;
    logic                 w_mac_last;

    assign w_x        = r_row[r_k];
    assign w_mac_last = (r_k == 3'd7) && (r_g == GW'(GROUPS - 1));

    idct_cos_rom #(
        .CW    (CW),
        .LANES (LANES)
    ) u_rom (
        .i_k (r_k),
        .i_n (w_n),
        .o_t (w_t)
    );

    // Lane l serves outputs n = g*LANES + l; group g selects which of its
    // accumulators is live while k sweeps 0..7.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [CW-1:0] w_coef;
        logic [PW-1:0]        w_prod;

        assign w_n[l*3 +: 3] = 3'(int'(r_g) * LANES + l);
        assign w_coef        = w_t[l*CW +: CW];
        // Both operands sign-extended to PW bits: the low PW bits of the
        // product are the exact signed product.
        assign w_prod = {{CW{w_x[DW-1]}}, w_x} * {{DW{w_coef[CW-1]}}, w_coef};

        for (genvar j = 0; j < GROUPS; j++) begin : g_acc
            logic signed [ACCW-1:0] r_acc;

            always_ff @(posedge clk) begin
                if (rst || r_state == LOAD) begin
                    r_acc <= '0;
                end else if (r_state == MAC && r_g == GW'(j)) begin
                    r_acc <= r_acc + {{(ACCW-PW){w_prod[PW-1]}}, w_prod};
                end
            end

            assign w_res[(j*LANES+l)*OW +: OW] =
                OW'(round_sat({{(64-ACCW){r_acc[ACCW-1]}}, r_acc}, CFRAC, OW));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_out       <= '0;
            r_k         <= '0;
            r_g         <= '0;
            for (int i = 0; i < N_PTS; i++) begin
                r_row[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        for (int i = 0; i < N_PTS; i++) begin
                            r_row[i] <= in_coeffs[i*DW +: DW];
                        end
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= LOAD;
                    end
                end
                LOAD: begin
                    r_k     <= '0;
                    r_g     <= '0;
                    r_state <= MAC;
                end
                MAC: begin
                    r_k <= r_k + 3'd1;
                    if (r_k == 3'd7) begin
                        if (w_mac_last) begin
                            r_state <= FIN;
                        end else begin
                            r_g <= r_g + GW'(1);
                        end
                    end
                end
                FIN: begin
                    r_out       <= w_res;
                    r_out_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_samples = r_out;
    assign busy        = r_busy;

endmodule

// File: tb/tb_idct_row_pipe.sv
// Scoreboard bench for idct_row_pipe: rows are pushed with their expected
// output at issue time, a negedge monitor pops and compares on each output
// handshake. Directed rows carry hand-computed results; random rows use a
// cosine model computed from $cos.
module tb_idct_row_pipe;

    localparam int DW    = 16;
    localparam int OW    = 12;
    localparam int CW    = 16;
    localparam int CFRAC = 14;
    localparam int LANES = 2;
    localparam int LAT   = 64 / LANES + 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [8*DW-1:0] in_coeffs;
    logic            out_valid;
    logic            out_ready;
    logic [8*OW-1:0] out_samples;
    logic            busy;

    logic ready_force;
    logic rand_ready;
    logic rand_bit;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8*OW-1:0] exp_q [$];
    string           name_q [$];

    assign out_ready = rand_ready ? rand_bit : ready_force;

    idct_row_pipe #(
        .DW    (DW),
        .OW    (OW),
        .CW    (CW),
        .CFRAC (CFRAC),
        .LANES (LANES)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_coeffs   (in_coeffs),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_samples (out_samples),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rand_bit = ($urandom_range(0, 3) != 0);
    end

    task automatic check_bit(input string nm, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", nm, act, req);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, req);
        end
    endtask

    task automatic check_vec(input string nm, input logic [8*OW-1:0] act, input logic [8*OW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, req);
        end
    endtask

    function automatic logic [8*DW-1:0] one_hot(input int k, input int v);
        logic [8*DW-1:0] r;
        r = '0;
        r[k*DW +: DW] = DW'(v);
        return r;
    endfunction

    function automatic logic [8*OW-1:0] mk_out(input int a0, input int a1, input int a2, input int a3,
                                               input int a4, input int a5, input int a6, input int a7);
        int v [8];
        logic [8*OW-1:0] r;
        v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
        v[4] = a4; v[5] = a5; v[6] = a6; v[7] = a7;
        for (int n = 0; n < 8; n++) begin
            r[n*OW +: OW] = OW'(v[n]);
        end
        return r;
    endfunction

    function automatic logic [8*OW-1:0] golden(input logic [8*DW-1:0] c);
        logic [8*OW-1:0]      r;
        longint               acc;
        longint               t;
        longint               y;
        longint               hi;
        longint               lo;
        real                  ck;
        real                  ang;
        logic signed [DW-1:0] xk;
        hi = (longint'(1) <<< (OW - 1)) - 1;
        lo = -(longint'(1) <<< (OW - 1));
        for (int n = 0; n < 8; n++) begin
            acc = 0;
            for (int k = 0; k < 8; k++) begin
                ck  = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
                ang = real'((2 * n + 1) * k) * 3.141592653589793 / 16.0;
                t   = longint'(real'(longint'(1) <<< CFRAC) * ck / 2.0 * $cos(ang));
                xk  = c[k*DW +: DW];
                acc = acc + longint'(xk) * t;
            end
            y = (acc + (longint'(1) <<< (CFRAC - 1))) >>> CFRAC;
            if (y > hi) y = hi;
            if (y < lo) y = lo;
            r[n*OW +: OW] = y[OW-1:0];
        end
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_row(input logic [8*DW-1:0] c, input logic [8*OW-1:0] e,
                            input bit expect_out, input string nm);
        int t;
        t = 0;
        in_coeffs = c;
        in_valid  = 1'b1;
        if (expect_out) begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 2000) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_%s: in_ready stayed 0 for %0d cycles, want 1", nm, t);
                if (expect_out) begin
                    void'(exp_q.pop_back());
                    void'(name_q.pop_back());
                end
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || in_valid) && t < budget) begin
            tick(1);
            t++;
        end
        check_int("drain_pending", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %h, want no output", out_samples);
            end else begin
                check_vec(name_q.pop_front(), out_samples, exp_q.pop_front());
            end
        end
    end

    initial begin
        int              cnt;
        logic [8*DW-1:0] c;
        logic [8*OW-1:0] dc_exp;
        logic [8*OW-1:0] ac_exp;

        dc_exp = mk_out(362, 362, 362, 362, 362, 362, 362, 362);
        ac_exp = mk_out(490, 416, 278, 98, -98, -278, -416, -490);

        rst         = 1'b1;
        in_valid    = 1'b0;
        in_coeffs   = '0;
        ready_force = 1'b1;
        rand_ready  = 1'b0;
        tick(3);
        check_bit("reset_in_ready", in_ready, 1'b1);
        check_bit("reset_out_valid", out_valid, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        check_vec("reset_out_samples", out_samples, '0);
        rst = 1'b0;
        tick(1);

        // DC row with latency and in-flight status
        send_row(one_hot(0, 1024), dc_exp, 1, "dc_pos");
        cnt = 0;
        while (!out_valid && cnt < 200) begin
            tick(1);
            cnt++;
            if (cnt == 10) begin
                check_bit("mac_busy", busy, 1'b1);
                check_bit("mac_in_ready", in_ready, 1'b0);
            end
        end
        check_int("latency", cnt, LAT);

        send_row(one_hot(0, -1024), mk_out(-362, -362, -362, -362, -362, -362, -362, -362), 1, "dc_neg");
        send_row(one_hot(1, 1000), ac_exp, 1, "ac1_pos");
        send_row(one_hot(1, -1000), mk_out(-490, -416, -278, -98, 98, 278, 416, 490), 1, "ac1_neg");
        send_row(one_hot(4, 1000), mk_out(354, -354, -354, 354, 354, -354, -354, 354), 1, "ac4");
        send_row(one_hot(0, 32767), mk_out(2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047), 1, "sat_pos");
        send_row(one_hot(0, -32768), mk_out(-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048), 1, "sat_neg");
        send_row('0, '0, 1, "zero");
        c = {8{16'h7FFF}};
        send_row(c, golden(c), 1, "full_scale");
        wait_drain(500);

        // Back-pressure: output held, second row waits for the handshake
        ready_force = 1'b0;
        send_row(one_hot(1, 1000), ac_exp, 1, "bp_row");
        cnt = 0;
        while (!out_valid && cnt < 200) begin
            tick(1);
            cnt++;
        end
        check_bit("bp_valid", out_valid, 1'b1);
        fork
            send_row(one_hot(0, 1024), dc_exp, 1, "bp_second");
        join_none
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check_vec("bp_hold", out_samples, ac_exp);
            check_bit("bp_in_ready", in_ready, 1'b0);
        end
        ready_force = 1'b1;
        wait_drain(500);

        // Reset in the middle of MAC discards the row
        send_row(one_hot(1, 1000), '0, 0, "aborted");
        tick(31);
        check_bit("pre_reset_busy", busy, 1'b1);
        rst = 1'b1;
        tick(1);
        check_bit("midrst_out_valid", out_valid, 1'b0);
        check_bit("midrst_in_ready", in_ready, 1'b1);
        check_bit("midrst_busy", busy, 1'b0);
        check_vec("midrst_out_samples", out_samples, '0);
        rst = 1'b0;
        tick(1);
        send_row(one_hot(0, 1024), dc_exp, 1, "after_reset");
        wait_drain(500);

        // Random rows with random output stalls
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            c = {$urandom, $urandom, $urandom, $urandom};
            if (i % 10 == 0) begin
                for (int k = 0; k < 8; k++) begin
                    c[k*DW +: DW] = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
                end
            end
            send_row(c, golden(c), 1, $sformatf("rand%0d", i));
        end
        wait_drain(2000);
        rand_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
